// File: rtl/clm_rand_feeder.sv
// Front-end for the CLM AES core: fills a random mask vector from an LFSR, issues requests, captures ciphertext.
// Latency: N_RAND+ cycles to fill, start pulse one cycle after acceptance, result one cycle after the core edge.
// Backpressure: host_ready_o gates start_i; requests outside READY are dropped, never queued.

package clm_rand_pkg;
  typedef logic [7:0] red_poly_t;
endpackage

module clm_rand_feeder
  import clm_rand_pkg::*;
#(
  parameter int N_RAND = 23,
  parameter int LFSR_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         seed_load,
  input  logic [LFSR_W-1:0]            seed,
  input  logic                         start_i,
  input  logic [127:0]                 plaintext_i,
  input  logic [127:0]                 key_i,
  input  logic [4:0]                   p_det_cfg,
  output logic                         host_ready_o,
  output logic                         done_o,
  output logic [127:0]                 ct_o,
  output logic                         core_drdy_i,
  output logic [127:0]                 core_plaintext,
  output logic [127:0]                 core_key,
  output logic [4:0]                   p_det,
  output red_poly_t [0:N_RAND-1]       random_vect,
  input  logic                         core_drdy_o,
  input  logic [127:0]                 core_ciphertext
);

  localparam int IDX_W = (N_RAND > 1) ? $clog2(N_RAND) : 1;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_READY = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LFSR_W-1:0]      r_lfsr;
  logic [LFSR_W-1:0]      w_lfsr_nxt;
  logic                   w_fb;
  red_poly_t              w_cand;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_drdy_s;
  logic                   r_drdy_d;
  logic                   w_rise;
  logic                   w_step;
  logic                   w_seed;
  logic                   w_write;
  logic                   w_accept;
  logic                   w_capture;

  // Fixed taps 31/21/1/0; the candidate mask byte is the low byte of the stepped state.
  assign w_fb       = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];
  assign w_lfsr_nxt = {r_lfsr[LFSR_W-2:0], w_fb};
  assign w_cand     = w_lfsr_nxt[7:0];

  // core_drdy_o is registered before edge detection, so completion lands one cycle after the edge is seen.
  assign w_rise = r_drdy_s & ~r_drdy_d;

  assign host_ready_o = (r_state == S_READY);
  assign core_drdy_i  = (r_state == S_ISSUE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control strobes; seed_load outranks start_i in READY.
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_seed      = 1'b0;
    w_write     = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_FILL: begin
        if (seed_load) begin
          w_seed = 1'b1;
        end else begin
          w_step = 1'b1;
          if (w_cand != '0) begin
            w_write = 1'b1;
            if (r_idx == IDX_W'(N_RAND - 1)) begin
              w_state_nxt = S_READY;
            end
          end
        end
      end
      S_READY: begin
        if (seed_load) begin
          w_seed      = 1'b1;
          w_state_nxt = S_FILL;
        end else if (start_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_rise) begin
          w_capture   = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  // LFSR: reseed (zero seed would lock up, so it becomes 1), step only while filling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_W'(1);
    end else if (w_seed) begin
      r_lfsr <= (seed == '0) ? LFSR_W'(1) : seed;
    end else if (w_step) begin
      r_lfsr <= w_lfsr_nxt;
    end
  end

  // Fill index: restarts on reseed or on completion, advances only on accepted candidates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_seed || w_capture) begin
      r_idx <= '0;
    end else if (w_write && (r_idx != IDX_W'(N_RAND - 1))) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  // Mask vector: old contents stay visible until overwritten by the next fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      random_vect <= '0;
    end else if (w_write) begin
      random_vect[r_idx] <= w_cand;
    end
  end

  // Core operands are captured on acceptance and held through ISSUE and WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_plaintext <= '0;
      core_key       <= '0;
      p_det          <= '0;
    end else if (w_accept) begin
      core_plaintext <= plaintext_i;
      core_key       <= key_i;
      p_det          <= p_det_cfg;
    end
  end

  // Completion edge detector; tracks core_drdy_o in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drdy_s <= 1'b0;
      r_drdy_d <= 1'b0;
    end else begin
      r_drdy_s <= core_drdy_o;
      r_drdy_d <= r_drdy_s;
    end
  end

  // Ciphertext capture with a single-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_o   <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= w_capture;
      if (w_capture) begin
        ct_o <= core_ciphertext;
      end
    end
  end

endmodule

// File: tb/tb_clm_rand_feeder.sv
// Directed bench for clm_rand_feeder: vector fill, reseed, request/complete handshake and reset abort.
// Inputs change 1 time unit after the rising edge; outputs are checked there as well.
// A hand-driven model core answers each request after a programmed delay.

module tb_clm_rand_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         seed_load;
  logic [31:0]  seed;
  logic         start_i;
  logic [127:0] plaintext_i;
  logic [127:0] key_i;
  logic [4:0]   p_det_cfg;
  logic         host_ready_o;
  logic         done_o;
  logic [127:0] ct_o;
  logic         core_drdy_i;
  logic [127:0] core_plaintext;
  logic [127:0] core_key;
  logic [4:0]   p_det;
  clm_rand_pkg::red_poly_t [0:22] random_vect;
  clm_rand_pkg::red_poly_t [0:22] snap;
  logic         core_drdy_o;
  logic [127:0] core_ciphertext;

  int n_vec = 0;
  int n_bad = 0;
  int n_issue = 0;
  int n_done = 0;

  typedef struct {
    int        idx;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [8];

  clm_rand_feeder #(.N_RAND(23), .LFSR_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .seed_load       (seed_load),
    .seed            (seed),
    .start_i         (start_i),
    .plaintext_i     (plaintext_i),
    .key_i           (key_i),
    .p_det_cfg       (p_det_cfg),
    .host_ready_o    (host_ready_o),
    .done_o          (done_o),
    .ct_o            (ct_o),
    .core_drdy_i     (core_drdy_i),
    .core_plaintext  (core_plaintext),
    .core_key        (core_key),
    .p_det           (p_det),
    .random_vect     (random_vect),
    .core_drdy_o     (core_drdy_o),
    .core_ciphertext (core_ciphertext)
  );

  always #5 clk = ~clk;

  // Count core start pulses and done pulses on the falling edge.
  always @(negedge clk) begin
    if (core_drdy_i) n_issue++;
    if (done_o)      n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name, input int limit, output int cycles);
    cycles = 0;
    while (!host_ready_o && cycles < limit) begin
      tick();
      cycles++;
    end
    check(name, {127'd0, host_ready_o}, 128'd1);
  endtask

  initial begin
    int cyc;
    int base_issue;
    int base_done;
    logic stable;

    // Reset-fill sequence from LFSR = 1: hand-stepped with taps 31/21/1/0.
    tbl[0] = '{0, 8'h03};
    tbl[1] = '{1, 8'h06};
    tbl[2] = '{2, 8'h0D};
    tbl[3] = '{3, 8'h1B};
    tbl[4] = '{4, 8'h36};
    tbl[5] = '{5, 8'h6D};
    tbl[6] = '{6, 8'hDB};
    tbl[7] = '{7, 8'hB6};

    rst_n = 1'b0; seed_load = 1'b0; seed = '0; start_i = 1'b0;
    plaintext_i = '0; key_i = '0; p_det_cfg = '0;
    core_drdy_o = 1'b0; core_ciphertext = '0;

    tick(); tick();
    check("rst host_ready", {127'd0, host_ready_o}, 128'd0);
    check("rst core_drdy_i", {127'd0, core_drdy_i}, 128'd0);
    check("rst done_o", {127'd0, done_o}, 128'd0);
    check("rst ct_o", ct_o, 128'd0);
    check("rst vect_zero", {127'd0, (random_vect == '0)}, 128'd1);

    // Fill latency after release: 23 cycles with no rejects.
    rst_n = 1'b1;
    wait_ready("fill ready", 100, cyc);
    check("fill cycles", 128'(cyc), 128'd23);

    for (int i = 0; i < 8; i++) begin
      check($sformatf("rv[%0d]", tbl[i].idx), 128'(random_vect[tbl[i].idx]), 128'(tbl[i].exp));
    end

    // Seed 0x80: 14 zero candidates, first write on the 15th FILL cycle.
    seed_load = 1'b1; seed = 32'h80;
    tick();
    seed_load = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("seed80 stale rv0", 128'(random_vect[0]), 128'h03);
    tick();
    check("seed80 rv0", 128'(random_vect[0]), 128'h01);
    wait_ready("seed80 ready", 200, cyc);
    check("seed80 rv1", 128'(random_vect[1]), 128'h03);
    check("seed80 rv2", 128'(random_vect[2]), 128'h06);

    // Seed 0 behaves as seed 1.
    seed_load = 1'b1; seed = 32'h0;
    tick();
    seed_load = 1'b0;
    tick();
    check("seed0 rv0", 128'(random_vect[0]), 128'h03);
    wait_ready("seed0 ready", 100, cyc);

    // Full encryption with ignored start/seed_load during WAIT.
    base_issue = n_issue; base_done = n_done;
    plaintext_i = 128'hff; key_i = '0; p_det_cfg = 5'd15; start_i = 1'b1;
    tick();
    start_i = 1'b0; plaintext_i = 128'hdead; key_i = 128'hbeef; p_det_cfg = 5'd2;
    check("issue drdy_i", {127'd0, core_drdy_i}, 128'd1);
    check("issue pt", core_plaintext, 128'hff);
    check("issue key", core_key, 128'h0);
    check("issue p_det", 128'(p_det), 128'd15);
    check("issue host_ready", {127'd0, host_ready_o}, 128'd0);
    snap = random_vect;
    stable = 1'b1;
    for (int i = 1; i < 40; i++) begin
      start_i   = (i == 5);
      seed_load = (i == 10);
      seed      = 32'h1234;
      tick();
      if (core_plaintext !== 128'hff || core_key !== 128'h0 || p_det !== 5'd15 ||
          random_vect !== snap || host_ready_o !== 1'b0 || core_drdy_i !== 1'b0)
        stable = 1'b0;
    end
    start_i = 1'b0; seed_load = 1'b0;
    check("wait operands stable", {127'd0, stable}, 128'd1);
    core_drdy_o = 1'b1; core_ciphertext = 128'hC0FFEE_0123_4567_89AB;
    tick();
    check("done not early", {127'd0, done_o}, 128'd0);
    tick();
    check("done pulse", {127'd0, done_o}, 128'd1);
    check("ct_o", ct_o, 128'hC0FFEE_0123_4567_89AB);
    core_drdy_o = 1'b0;
    tick();
    check("done one cycle", {127'd0, done_o}, 128'd0);
    check("done count", 128'(n_done - base_done), 128'd1);

    // start_i during FILL is ignored.
    plaintext_i = 128'h77; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("fill start pt", core_plaintext, 128'hff);
    wait_ready("refill ready", 100, cyc);
    check("issue count", 128'(n_issue - base_issue), 128'd1);

    // seed_load and start_i together in READY: reseed wins.
    seed_load = 1'b1; seed = 32'h1; start_i = 1'b1; plaintext_i = 128'h1234;
    tick();
    seed_load = 1'b0; start_i = 1'b0;
    check("both host_ready", {127'd0, host_ready_o}, 128'd0);
    check("both drdy_i", {127'd0, core_drdy_i}, 128'd0);
    check("both pt", core_plaintext, 128'hff);
    tick();
    check("both rv0", 128'(random_vect[0]), 128'h03);
    wait_ready("both ready", 100, cyc);
    check("both issue count", 128'(n_issue - base_issue), 128'd1);

    // Reset during WAIT clears everything; a later core edge is not reported.
    plaintext_i = 128'habc; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort outputs zero",
          {127'd0, (host_ready_o | done_o | core_drdy_i | (ct_o != '0) | (core_plaintext != '0) |
                    (core_key != '0) | (p_det != '0) | (random_vect != '0))}, 128'd0);
    base_done = n_done;
    tick();
    rst_n = 1'b1; core_drdy_o = 1'b1; core_ciphertext = 128'h5555;
    for (int i = 0; i < 30; i++) tick();
    core_drdy_o = 1'b0;
    check("abort no done", 128'(n_done - base_done), 128'd0);
    check("abort ct_o", ct_o, 128'd0);
    wait_ready("abort ready", 100, cyc);

    // New request after recovery completes normally.
    base_issue = n_issue;
    plaintext_i = 128'h1111; key_i = 128'h2222; p_det_cfg = 5'd3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("rec drdy_i", {127'd0, core_drdy_i}, 128'd1);
    check("rec key", core_key, 128'h2222);
    for (int i = 0; i < 5; i++) tick();
    core_drdy_o = 1'b1; core_ciphertext = 128'hE0E0;
    tick(); tick();
    check("rec done", {127'd0, done_o}, 128'd1);
    check("rec ct_o", ct_o, 128'hE0E0);
    core_drdy_o = 1'b0;
    tick();
    check("rec issue count", 128'(n_issue - base_issue), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/clm_rand_feeder.md
# clm_rand_feeder

Front-end stage directly upstream of the CLM AES core. Accepts encryption requests from the host and generates a fresh 23-element random mask vector per encryption from an internal LFSR, rejecting zero elements. Presents plaintext, key, `p_det` and `random_vect` to the core and holds them stable for the whole encryption. Captures the core's ciphertext when it signals completion.

## Interface
- `N_RAND`, default 23: number of `red_poly_t` mask elements.
- `LFSR_W`, default 32: LFSR width. Fixed feedback taps 31/21/1/0.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `seed_load` in 1: load `seed` into the LFSR and restart the fill.
- `seed` in 32: new LFSR state; 0 is replaced by 32'h1.
- `start_i` in 1: host request; accepted only while `host_ready_o`=1.
- `plaintext_i` in 128, `key_i` in 128, `p_det_cfg` in 5: request data, sampled on acceptance.
- `host_ready_o` out 1: vector filled and no encryption in flight.
- `done_o` out 1: one-cycle pulse when `ct_o` updates.
- `ct_o` out 128: last captured ciphertext.
- `core_drdy_i` out 1: one-cycle start pulse to the core.
- `core_plaintext`, `core_key` out 128; `p_det` out 5; `random_vect` out `red_poly_t [0:N_RAND-1]`: core operands.
- `core_drdy_o` in 1, `core_ciphertext` in 128: core completion signal and result.

## Operation
- Reset values:
  - state = FILL, idx = 0, LFSR = 32'h1.
  - All outputs = 0, including every `random_vect` element.
  - Edge-detect register = 0.
- LFSR step: `fb = s[31]^s[21]^s[1]^s[0]`; `s <= {s[30:0], fb}`. Candidate byte = new `s[7:0]`.
- FILL: the LFSR steps every cycle.
  - Candidate ≠ 0: write `random_vect[idx]`, then idx++.
  - Candidate = 0: discard; idx unchanged.
  - Write with idx = N_RAND-1 → READY.
- READY: `host_ready_o` = 1 and the LFSR is frozen.
  - On `start_i`: latch `plaintext_i`, `key_i`, `p_det_cfg` into the core outputs, then → ISSUE.
- ISSUE: lasts one cycle with `core_drdy_i` = 1, then → WAIT.
- WAIT: all core operands are held constant.
  - On a rising edge of `core_drdy_o` (registered previous value = 0, current = 1): `ct_o <= core_ciphertext`, pulse `done_o`, idx = 0, → FILL.
  - The edge register tracks `core_drdy_o` in every state.
- `seed_load`:
  - Honoured in FILL and READY: LFSR <= seed (0 → 1), idx = 0, → FILL. Stale vector contents remain until overwritten.
  - Ignored in ISSUE and WAIT.
  - `seed_load` and `start_i` in the same READY cycle: `seed_load` wins and `start_i` is dropped.
- `start_i` outside READY is ignored; there is no queueing.
- `rst_n` asserted mid-encryption: all state clears immediately, and a later `core_drdy_o` edge is not reported.

## Timing
- Fill latency: N_RAND cycles from entering FILL to READY with no rejects, plus one cycle per rejected zero byte. The first READY after reset release is at cycle 23 at the earliest.
- Request to core start: `start_i` accepted at edge k → `core_drdy_i` high during cycle k+1.
- Completion: `core_drdy_o` rises before edge m → `ct_o`/`done_o` valid after edge m+1 (one cycle of edge detect).
- `host_ready_o` is low from acceptance until the refill completes.

## Test plan
- Reset, release with no seed load → `random_vect[0..3]` = 8'h03, 8'h06, 8'h0D, 8'h1B; `host_ready_o` rises 23 cycles after release.
- `seed_load` with `seed`=32'h80 → 14 zero candidates rejected; `random_vect[0]` = 8'h01, written on the 15th FILL cycle.
- `start_i` with `plaintext_i`=128'hff, `key_i`=0, `p_det_cfg`=15 → `core_drdy_i` pulses exactly once; operands stay stable until a model core raises `core_drdy_o` 40 cycles later; then `ct_o` equals the core value and `done_o` pulses once.
- `start_i` during FILL and during WAIT → ignored; no second `core_drdy_i`.
- `seed_load` during WAIT → ignored. Simultaneous `seed_load` and `start_i` in READY → FILL restarts and no core start is issued.
- `rst_n` pulsed low during WAIT → all outputs 0 immediately. After a refill, a new request completes normally.
